// File: rtl/red_pitaya_sort_seq.sv
// Sorting sequencer: qualifies a FADS trigger by minimum width, then emits a
// delayed, fixed-width ASG trigger pulse followed by a dead time.
module red_pitaya_sort_seq #(
  parameter int TW = 24,
  parameter int CW = 32
) (
  input  logic        adc_clk_i,
  input  logic        adc_rstn_i,
  input  logic        sort_trig_i,
  output logic        asg_trig_o,
  output logic        busy_o,
  input  logic [31:0] sys_addr,
  input  logic [31:0] sys_wdata,
  input  logic [3:0]  sys_sel,
  input  logic        sys_wen,
  input  logic        sys_ren,
  output logic [31:0] sys_rdata,
  output logic        sys_err,
  output logic        sys_ack
);

  typedef enum logic [2:0] {S_IDLE, S_QUAL, S_DELAY, S_PULSE, S_DEAD} state_t;

  localparam logic [19:0] A_CTRL      = 20'h00;
  localparam logic [19:0] A_MIN_WIDTH = 20'h04;
  localparam logic [19:0] A_DELAY     = 20'h08;
  localparam logic [19:0] A_PULSE_W   = 20'h0C;
  localparam logic [19:0] A_DEAD_T    = 20'h10;
  localparam logic [19:0] A_EVT_CNT   = 20'h14;
  localparam logic [19:0] A_FIRE_CNT  = 20'h18;
  localparam logic [19:0] A_DROP_CNT  = 20'h1C;

  state_t        state, state_next;
  logic [TW-1:0] cnt, cnt_next;
  logic          qualify, asg_next;
  logic          armed, trig_q;

  logic          enable;
  logic [TW-1:0] cfg_min_width, cfg_delay, cfg_pulse_w, cfg_dead_t;
  logic [TW-1:0] wrk_delay, wrk_pulse_w, wrk_dead_t;
  logic [CW-1:0] evt_cnt, fire_cnt, drop_cnt;

  logic [19:0]   addr;
  logic          wr_ctrl, ctrl_off, cnt_clr;
  logic [TW-1:0] mw_eff;
  logic          drop_evt, fire_evt;
  logic [31:0]   rd_mux;
  logic          unused_bits;

  assign addr        = sys_addr[19:0];
  assign wr_ctrl     = sys_wen && (addr == A_CTRL);
  assign ctrl_off    = wr_ctrl && !sys_wdata[0];
  assign cnt_clr     = wr_ctrl && sys_wdata[1];
  assign mw_eff      = (cfg_min_width == '0) ? TW'(1) : cfg_min_width;
  assign unused_bits = ^{sys_sel, sys_addr[31:20], sys_wdata};
  assign sys_err     = 1'b0;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    qualify    = 1'b0;
    case (state)
      S_IDLE: begin
        if (enable && armed && sort_trig_i) begin
          if (mw_eff == TW'(1)) begin
            qualify = 1'b1;
          end else begin
            state_next = S_QUAL;
            cnt_next   = TW'(1);
          end
        end
      end
      S_QUAL: begin
        if (!sort_trig_i)                   state_next = S_IDLE;
        else if (cnt + TW'(1) >= mw_eff)    qualify    = 1'b1;
        else                                cnt_next   = cnt + TW'(1);
      end
      S_DELAY: begin
        if (cnt >= wrk_delay) begin
          state_next = S_PULSE;
          cnt_next   = TW'(1);
        end else begin
          cnt_next = cnt + TW'(1);
        end
      end
      S_PULSE: begin
        if (cnt >= wrk_pulse_w) begin
          state_next = (wrk_dead_t == '0) ? S_IDLE : S_DEAD;
          cnt_next   = TW'(1);
        end else begin
          cnt_next = cnt + TW'(1);
        end
      end
      S_DEAD: begin
        if (cnt >= wrk_dead_t) state_next = S_IDLE;
        else                   cnt_next   = cnt + TW'(1);
      end
      default: state_next = S_IDLE;
    endcase
    // Qualification decides the path from the live DELAY register, the same
    // value that is latched into the working copy on this edge.
    if (qualify) begin
      state_next = (cfg_delay == '0) ? S_PULSE : S_DELAY;
      cnt_next   = TW'(1);
    end
    if (!enable || ctrl_off) begin
      state_next = S_IDLE;
      qualify    = 1'b0;
    end
  end

  always_comb begin
    busy_o   = (state != S_IDLE);
    asg_next = (state_next == S_PULSE);
  end

  assign drop_evt = sort_trig_i && !trig_q && (state inside {S_DELAY, S_PULSE, S_DEAD});
  assign fire_evt = asg_next && !asg_trig_o;

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      armed       <= 1'b0;
      trig_q      <= 1'b0;
      asg_trig_o  <= 1'b0;
      wrk_delay   <= '0;
      wrk_pulse_w <= TW'(1);
      wrk_dead_t  <= '0;
    end else begin
      trig_q     <= sort_trig_i;
      asg_trig_o <= asg_next;
      if (state == S_IDLE && state_next != S_IDLE) armed <= 1'b0;
      else if (!sort_trig_i)                       armed <= 1'b1;
      if (qualify) begin
        wrk_delay   <= cfg_delay;
        wrk_pulse_w <= (cfg_pulse_w == '0) ? TW'(1) : cfg_pulse_w;
        wrk_dead_t  <= cfg_dead_t;
      end
    end
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      evt_cnt  <= '0;
      fire_cnt <= '0;
      drop_cnt <= '0;
    end else if (cnt_clr) begin
      evt_cnt  <= '0;
      fire_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (qualify)  evt_cnt  <= sat_inc(evt_cnt);
      if (fire_evt) fire_cnt <= sat_inc(fire_cnt);
      if (drop_evt) drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      A_CTRL:      rd_mux = {31'b0, enable};
      A_MIN_WIDTH: rd_mux = 32'(cfg_min_width);
      A_DELAY:     rd_mux = 32'(cfg_delay);
      A_PULSE_W:   rd_mux = 32'(cfg_pulse_w);
      A_DEAD_T:    rd_mux = 32'(cfg_dead_t);
      A_EVT_CNT:   rd_mux = 32'(evt_cnt);
      A_FIRE_CNT:  rd_mux = 32'(fire_cnt);
      A_DROP_CNT:  rd_mux = 32'(drop_cnt);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
    if (!adc_rstn_i) begin
      enable        <= 1'b0;
      cfg_min_width <= TW'(1);
      cfg_delay     <= '0;
      cfg_pulse_w   <= TW'(125);
      cfg_dead_t    <= '0;
      sys_ack       <= 1'b0;
      sys_rdata     <= '0;
    end else begin
      sys_ack <= sys_wen || sys_ren;
      if (sys_ren) sys_rdata <= rd_mux;
      if (sys_wen) begin
        case (addr)
          A_CTRL:      enable        <= sys_wdata[0];
          A_MIN_WIDTH: cfg_min_width <= sys_wdata[TW-1:0];
          A_DELAY:     cfg_delay     <= sys_wdata[TW-1:0];
          A_PULSE_W:   cfg_pulse_w   <= sys_wdata[TW-1:0];
          A_DEAD_T:    cfg_dead_t    <= sys_wdata[TW-1:0];
          default:     ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_sort_seq.sv
// Directed bench for red_pitaya_sort_seq: register vectors plus hand-timed
// trigger sequences against cycle numbers computed from the trigger edge.
module tb_red_pitaya_sort_seq;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        trig = 1'b0;
  logic        asg, busy;
  logic [31:0] sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic [3:0]  sys_sel = 4'hF;
  logic        sys_wen = 1'b0;
  logic        sys_ren = 1'b0;
  logic [31:0] sys_rdata;
  logic        sys_err, sys_ack;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_rise = 0;
  int rise_cyc = 0;
  int cur_len = 0;
  logic asg_prev = 1'b0;

  red_pitaya_sort_seq #(.TW(24), .CW(32)) dut (
    .adc_clk_i  (clk),
    .adc_rstn_i (rstn),
    .sort_trig_i(trig),
    .asg_trig_o (asg),
    .busy_o     (busy),
    .sys_addr   (sys_addr),
    .sys_wdata  (sys_wdata),
    .sys_sel    (sys_sel),
    .sys_wen    (sys_wen),
    .sys_ren    (sys_ren),
    .sys_rdata  (sys_rdata),
    .sys_err    (sys_err),
    .sys_ack    (sys_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: rise cycle is the posedge count at which asg went high.
  always @(negedge clk) begin
    if (asg && !asg_prev) begin
      n_rise++;
      rise_cyc = cyc;
      cur_len  = 0;
    end
    if (asg) cur_len++;
    asg_prev = asg;
  end

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // NOTE: stimulus is driven with blocking assignments at the falling edge so
  // the DUT samples settled values at the next rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    sys_addr  = a;
    sys_wdata = d;
    sys_wen   = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
    @(negedge clk);
    sys_addr = a;
    sys_ren  = 1'b1;
    @(negedge clk);
    sys_ren = 1'b0;
    d   = sys_rdata;
    ack = sys_ack;
  endtask

  task automatic check_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        ack;
    bus_read(a, d, ack);
    check(name, d, exp);
  endtask

  task automatic cfg(input int mw, input int dl, input int pw, input int dt);
    bus_write(32'h04, mw);
    bus_write(32'h08, dl);
    bus_write(32'h0C, pw);
    bus_write(32'h10, dt);
  endtask

  task automatic check_pulse(input string name, input int base, input int exp_rise, input int exp_len);
    check({name, "_count"}, n_rise, base + 1);
    check({name, "_start"}, rise_cyc, exp_rise);
    check({name, "_len"}, cur_len, exp_len);
  endtask

  initial begin
    logic [31:0] d;
    logic        ack;
    int          e0, e1, base;

    vecs[0]  = '{1'b0, 32'h04, 32'h0, 32'h1};
    vecs[1]  = '{1'b0, 32'h08, 32'h0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0C, 32'h0, 32'd125};
    vecs[3]  = '{1'b0, 32'h10, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 32'h00, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 32'h14, 32'h0, 32'h0};
    vecs[6]  = '{1'b0, 32'h18, 32'h0, 32'h0};
    vecs[7]  = '{1'b0, 32'h1C, 32'h0, 32'h0};
    vecs[8]  = '{1'b0, 32'h20, 32'h0, 32'h0};
    vecs[9]  = '{1'b1, 32'h0C, 32'h7, 32'h7};
    vecs[10] = '{1'b1, 32'h04, 32'hFFFF_FFFF, 32'h00FF_FFFF};
    vecs[11] = '{1'b1, 32'h0010_0008, 32'h9, 32'h9};
    vecs[12] = '{1'b1, 32'h14, 32'h5, 32'h0};
    vecs[13] = '{1'b1, 32'h24, 32'h1, 32'h0};
    vecs[14] = '{1'b1, 32'h00, 32'h1, 32'h1};
    vecs[15] = '{1'b1, 32'h00, 32'h3, 32'h1};
    vecs[16] = '{1'b1, 32'h00, 32'h0, 32'h0};
    vecs[17] = '{1'b1, 32'h10, 32'hABCDEF, 32'hABCDEF};

    // Reset state, with a read request held during reset.
    sys_ren = 1'b1;
    tick(3);
    check("rst_asg", asg, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", sys_ack, 0);
    check("rst_err", sys_err, 0);
    check("rst_rdata", sys_rdata, 0);
    sys_ren = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(2);

    for (int i = 0; i < 18; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
      bus_read(vecs[i].addr, d, ack);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp);
      check($sformatf("vec%0d_ack", i), ack, 1);
    end

    // Ack timing: high exactly one cycle after a write request.
    @(negedge clk);
    sys_addr = 32'h0C; sys_wdata = 32'h7; sys_wen = 1'b1;
    @(negedge clk);
    sys_wen = 1'b0;
    check("wr_ack_hi", sys_ack, 1);
    @(negedge clk);
    check("wr_ack_lo", sys_ack, 0);
    check("err_zero", sys_err, 0);

    // Nominal sequence: MW=3, DELAY=10, PULSE_W=5.
    cfg(3, 10, 5, 0);
    bus_write(32'h00, 32'h3);
    base = n_rise;
    trig = 1'b1; e0 = cyc + 1;
    tick(1);
    check("nom_busy", busy, 1);
    tick(3);
    trig = 1'b0;
    tick(25);
    check_pulse("nom", base, e0 + 12, 5);
    check("nom_idle", busy, 0);
    check_reg("nom_evt", 32'h14, 1);
    check_reg("nom_fire", 32'h18, 1);

    // Zero MIN_WIDTH/DELAY/PULSE_W act as 1/0/1: pulse on the detection edge.
    cfg(0, 0, 0, 0);
    base = n_rise;
    trig = 1'b1; e0 = cyc + 1;
    tick(1);
    check("zero_asg", asg, 1);
    trig = 1'b0;
    tick(5);
    check_pulse("zero", base, e0, 1);
    check_reg("zero_evt", 32'h14, 2);

    // Too-short trigger: MW=4, high for 3 samples.
    cfg(4, 0, 5, 0);
    bus_write(32'h00, 32'h3);
    base = n_rise;
    trig = 1'b1;
    tick(2);
    check("short_busy", busy, 1);
    tick(1);
    trig = 1'b0;
    tick(2);
    check("short_idle", busy, 0);
    check("short_nopulse", n_rise, base);
    check_reg("short_evt", 32'h14, 0);

    // Edges during PULSE and DEAD are dropped; an edge after DEAD fires.
    cfg(1, 2, 5, 50);
    bus_write(32'h00, 32'h3);
    base = n_rise;
    trig = 1'b1; e0 = cyc + 1;
    tick(1); trig = 1'b0;
    tick(3); trig = 1'b1;
    tick(1); trig = 1'b0;
    tick(15);
    check("dead_busy", busy, 1);
    trig = 1'b1;
    tick(1); trig = 1'b0;
    tick(60);
    check_pulse("drop", base, e0 + 2, 5);
    check("drop_idle", busy, 0);
    check_reg("drop_cnt", 32'h1C, 2);
    check_reg("drop_evt", 32'h14, 1);
    base = n_rise;
    trig = 1'b1; e1 = cyc + 1;
    tick(1); trig = 1'b0;
    tick(10);
    check_pulse("rearm", base, e1 + 2, 5);
    check_reg("rearm_fire", 32'h18, 2);

    // Counter clear while busy, then disable forces IDLE.
    bus_write(32'h00, 32'h3);
    check_reg("clr_evt", 32'h14, 0);
    check_reg("clr_fire", 32'h18, 0);
    check_reg("clr_drop", 32'h1C, 0);
    bus_write(32'h00, 32'h0);
    check("dis_dead_idle", busy, 0);

    // Level held high for 1000 cycles fires exactly once.
    cfg(1, 3, 4, 0);
    bus_write(32'h00, 32'h1);
    base = n_rise;
    trig = 1'b1; e0 = cyc + 1;
    tick(1000);
    trig = 1'b0;
    tick(3);
    check_pulse("hold", base, e0 + 3, 4);
    check_reg("hold_evt", 32'h14, 1);
    check_reg("hold_drop", 32'h1C, 0);

    // Disable during DELAY: IDLE next cycle, no pulse.
    cfg(1, 10, 5, 0);
    base = n_rise;
    trig = 1'b1;
    tick(1); trig = 1'b0;
    tick(3);
    check("dly_busy", busy, 1);
    bus_write(32'h00, 32'h0);
    check("dly_off_idle", busy, 0);
    check("dly_off_asg", asg, 0);
    tick(20);
    check("dly_nopulse", n_rise, base);
    check_reg("dly_fire", 32'h18, 1);
    check_reg("dly_evt", 32'h14, 2);

    // Reset mid-pulse aborts at once; a held-high trigger must drop first.
    cfg(1, 0, 125, 0);
    bus_write(32'h00, 32'h1);
    trig = 1'b1;
    tick(5);
    check("mid_asg", asg, 1);
    rstn = 1'b0;
    #1;
    check("mid_rst_asg", asg, 0);
    check("mid_rst_busy", busy, 0);
    tick(2);
    rstn = 1'b1;
    bus_write(32'h00, 32'h1);
    base = n_rise;
    tick(10);
    check("mid_noretrig", n_rise, base);
    check("mid_idle", busy, 0);
    check_reg("mid_pw", 32'h0C, 125);
    check_reg("mid_evt", 32'h14, 0);
    trig = 1'b0;
    tick(2);
    trig = 1'b1;
    tick(1);
    check("mid_rearm_busy", busy, 1);
    check("mid_rearm_asg", asg, 1);
    trig = 1'b0;
    bus_write(32'h00, 32'h0);
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/red_pitaya_sort_seq.md
RED_PITAYA_SORT_SEQ -- requirements
Module: red_pitaya_sort_seq

Interface
REQ-001 SHALL have parameter: TW, 24, width of timing registers (min width, delay, pulse width, dead time).
REQ-002 SHALL have parameter: CW, 32, width of event counters.
REQ-003 SHALL have port: adc_clk_i  input  1  ADC clock; the block's only clock; all state on rising edge.
REQ-004 SHALL have port: adc_rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: sort_trig_i  input  1  sort trigger from the FADS threshold comparator.
REQ-006 SHALL have port: asg_trig_o  output  1  registered sorting pulse to the ASG external-trigger input.
REQ-007 SHALL have port: busy_o  output  1  high whenever the state is not IDLE.
REQ-008 SHALL have ports: sys_addr input 32, sys_wdata input 32, sys_sel input 4, sys_wen input 1, sys_ren input 1, sys_rdata output 32, sys_err output 1, sys_ack output 1; standard system-bus slave.

Function
REQ-009 SHALL decode sys_addr[19:0]: 0x00 CTRL (bit0 enable, bit1 counter-clear, write-only, self-clearing), 0x04 MIN_WIDTH, 0x08 DELAY, 0x0C PULSE_W, 0x10 DEAD_T (RW, TW bits), 0x14 EVT_CNT, 0x18 FIRE_CNT, 0x1C DROP_CNT (RO, CW bits).
REQ-010 SHALL assert sys_ack exactly one cycle after any cycle with sys_wen|sys_ren; sys_err always 0; unmapped reads return 0; writes to RO or unmapped addresses ignored; sys_sel ignored.
REQ-011 SHALL read back RW registers zero-extended to 32 bits; CTRL reads {30'b0, 1'b0, enable}.
REQ-012 SHALL implement FSM states IDLE, QUAL, DELAY, PULSE, DEAD.
REQ-013 SHALL keep an armed flag: cleared on IDLE->QUAL, set whenever sort_trig_i samples low; a level held high never retriggers.
REQ-014 IDLE->QUAL when enable=1, armed=1 and sort_trig_i samples high (edge E0).
REQ-015 QUAL: return to IDLE if sort_trig_i samples low before MW consecutive high samples (MW = max(MIN_WIDTH,1)); nothing counted.
REQ-016 On the MW-th consecutive high sample: increment EVT_CNT, latch DELAY/PULSE_W/DEAD_T into working copies, go to DELAY (or directly PULSE if DELAY=0).
REQ-017 asg_trig_o SHALL first be high in the cycle following edge E0+MW-1+DELAY and stay high exactly max(PULSE_W,1) cycles; FIRE_CNT increments on its rising edge.
REQ-018 After PULSE: DEAD for DEAD_T cycles with asg_trig_o low, then IDLE; DEAD_T=0 returns directly to IDLE.
REQ-019 Rising edges of sort_trig_i while in DELAY, PULSE or DEAD SHALL increment DROP_CNT and be otherwise ignored.
REQ-020 Register writes during an active sequence SHALL affect only the next sequence.
REQ-021 Writing enable=0 in any state SHALL force IDLE next cycle; asg_trig_o low next cycle; counters retained.
REQ-022 Counters SHALL saturate at all-ones; counter-clear zeroes all three; clear wins over simultaneous increment.

Reset
REQ-023 While adc_rstn_i=0, asynchronously: state IDLE, armed=0, asg_trig_o=0, busy_o=0, enable=0, MIN_WIDTH=1, DELAY=0, PULSE_W=125, DEAD_T=0, all counters 0, sys_ack=0, sys_err=0, sys_rdata=0.
REQ-024 Reset asserted mid-sequence SHALL abort immediately; after release, sort_trig_i must sample low before any new detection.

Verification
REQ-025 enable=1, MIN_WIDTH=3, DELAY=10, PULSE_W=5, trig high 4 cycles -> asg_trig_o high 5 cycles starting after edge E0+12; EVT_CNT=1, FIRE_CNT=1.
REQ-026 MIN_WIDTH=4, trig high 3 cycles -> no pulse, EVT_CNT=0, busy_o back low after trig falls.
REQ-027 DEAD_T=50, second trig edge during PULSE and third during DEAD -> single pulse, DROP_CNT=2; trig edge after DEAD -> new pulse.
REQ-028 trig held high 1000 cycles -> exactly one pulse; write enable=0 during DELAY -> no pulse, IDLE next cycle.
REQ-029 Bus: write 0x0C=7, read 0x0C -> 7 with ack one cycle later; read 0x20 -> 0; write CTRL bit1 -> all counters read 0.
